// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - section encodings, FSM states and sizing helper for the debug dump collector
package debug_pkg;

  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_MEM = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_PC  = 2'd1,
    S_REG = 2'd2,
    S_MEM = 2'd3
  } state_t;

  // Bytes per assembled word.
  function automatic int bpw(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// rtl/debug_word_assembler.sv - little-endian byte-to-word shift-in register
module debug_word_assembler
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int BPW = bpw(DATA_WIDTH, BYTE_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] byte_cnt;

  assign word_done = byte_valid && (byte_cnt == CW'(BPW - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      byte_cnt <= word_done ? '0 : byte_cnt + CW'(1);
    end
  end

  generate
    if (BPW == 1) begin : g_single
      assign word = byte_in;
    end else begin : g_multi
      // Holds the upper BPW-1 bytes; each new byte enters at the top so the first lands lowest.
      logic [DATA_WIDTH-BYTE_WIDTH-1:0] shreg;

      assign word = {byte_in, shreg};

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          shreg <= '0;
        end else if (clear) begin
          shreg <= '0;
        end else if (byte_valid) begin
          shreg <= word[DATA_WIDTH-1:BYTE_WIDTH];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/debug_frame_collector.sv
// rtl/debug_frame_collector.sv - assembles the debug unit dump stream into tagged PC/REG/MEM words
module debug_frame_collector
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int N_REGS         = 32,
  parameter int N_MEM          = 32,
  parameter int IDX_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [BYTE_WIDTH-1:0] i_rx_byte,
  input  logic                  i_flush,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [1:0]            o_section,
  output logic [IDX_WIDTH-1:0]  o_index,
  output logic                  o_frame_done,
  output logic                  o_frame_error,
  output logic                  o_busy,
  output logic [15:0]           o_frame_count
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state;
  state_t                next_state;
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [TW-1:0]         idle_cnt;
  logic [15:0]           frame_cnt;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  asm_done;
  logic                  timeout_hit;
  logic                  accept;
  logic                  last_reg;
  logic                  last_mem;
  logic                  emit;
  logic                  frame_end;
  logic [1:0]            cur_section;

  // Flush and timeout both outrank a byte arriving in the same cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (idle_cnt == TW'(TIMEOUT_CYCLES));
  assign accept      = i_rx_done && !i_flush && !timeout_hit;
  assign last_reg    = (word_idx == IDX_WIDTH'(N_REGS - 1));
  assign last_mem    = (word_idx == IDX_WIDTH'(N_MEM - 1));

  debug_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_assembler (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .clear     (i_flush || timeout_hit),
    .byte_valid(accept),
    .byte_in   (i_rx_byte),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (i_flush || timeout_hit) begin
      next_state = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    next_state = asm_done ? S_REG : S_PC;
        S_PC:    if (asm_done) next_state = S_REG;
        S_REG:   if (asm_done && last_reg) next_state = S_MEM;
        S_MEM:   if (asm_done && last_mem) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    emit        = accept && asm_done;
    frame_end   = 1'b0;
    cur_section = SEC_PC;
    o_busy      = (state != IDLE);
    case (state)
      S_REG: cur_section = SEC_REG;
      S_MEM: begin
        cur_section = SEC_MEM;
        frame_end   = emit && last_mem;
      end
      default: cur_section = SEC_PC;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_idx      <= '0;
      idle_cnt      <= '0;
      frame_cnt     <= '0;
      o_word_valid  <= 1'b0;
      o_word        <= '0;
      o_section     <= SEC_PC;
      o_index       <= '0;
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      if (i_flush || timeout_hit || (next_state != state)) begin
        word_idx <= '0;
      end else if (emit) begin
        word_idx <= word_idx + IDX_WIDTH'(1);
      end

      if ((state == IDLE) || i_rx_done || i_flush || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      o_word_valid  <= emit;
      o_frame_done  <= frame_end;
      o_frame_error <= timeout_hit;
      if (emit) begin
        o_word    <= asm_word;
        o_section <= cur_section;
        o_index   <= (cur_section == SEC_PC) ? '0 : word_idx;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign o_frame_count = frame_cnt;

endmodule

// File: tb/tb_debug_frame_collector.sv
// tb/tb_debug_frame_collector.sv - directed self-checking bench for debug_frame_collector
module tb_debug_frame_collector;

  typedef struct packed {
    logic [1:0]  sec;
    logic [4:0]  idx;
    logic [31:0] word;
    logic        done;
  } rec_t;

  logic        clk;
  logic        rst;

  logic        b_rx_done, b_flush;
  logic [7:0]  b_rx_byte;
  logic        b_word_valid, b_frame_done, b_frame_error, b_busy;
  logic [31:0] b_word;
  logic [1:0]  b_section;
  logic [4:0]  b_index;
  logic [15:0] b_frame_count;

  logic        s_rx_done, s_flush;
  logic [7:0]  s_rx_byte;
  logic        s_word_valid, s_frame_done, s_frame_error, s_busy;
  logic [15:0] s_word;
  logic [1:0]  s_section;
  logic [1:0]  s_index;
  logic [15:0] s_frame_count;

  rec_t cap_b[$];
  rec_t cap_s[$];
  int   err_b;
  int   err_s;
  int   checks;
  int   errors;

  debug_frame_collector #(
    .TIMEOUT_CYCLES(100)
  ) b_dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_done    (b_rx_done),
    .i_rx_byte    (b_rx_byte),
    .i_flush      (b_flush),
    .o_word_valid (b_word_valid),
    .o_word       (b_word),
    .o_section    (b_section),
    .o_index      (b_index),
    .o_frame_done (b_frame_done),
    .o_frame_error(b_frame_error),
    .o_busy       (b_busy),
    .o_frame_count(b_frame_count)
  );

  debug_frame_collector #(
    .DATA_WIDTH(16),
    .N_REGS    (4),
    .N_MEM     (2),
    .IDX_WIDTH (2)
  ) s_dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_done    (s_rx_done),
    .i_rx_byte    (s_rx_byte),
    .i_flush      (s_flush),
    .o_word_valid (s_word_valid),
    .o_word       (s_word),
    .o_section    (s_section),
    .o_index      (s_index),
    .o_frame_done (s_frame_done),
    .o_frame_error(s_frame_error),
    .o_busy       (s_busy),
    .o_frame_count(s_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    rec_t r;
    if (b_word_valid) begin
      r.sec = b_section; r.idx = b_index; r.word = b_word; r.done = b_frame_done;
      cap_b.push_back(r);
    end
    if (s_word_valid) begin
      r.sec = s_section; r.idx = {3'b000, s_index}; r.word = {16'h0000, s_word}; r.done = s_frame_done;
      cap_s.push_back(r);
    end
    if (b_frame_error) err_b++;
    if (s_frame_error) err_s++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_b(input logic [7:0] v);
    b_rx_byte = v;
    b_rx_done = 1'b1;
    @(negedge clk);
    b_rx_done = 1'b0;
  endtask

  task automatic send_word_b(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_b(w[8*i +: 8]);
  endtask

  task automatic send_frame_b(input logic [31:0] pc);
    send_word_b(pc);
    for (int i = 0; i < 32; i++) send_word_b(32'(i));
    for (int j = 0; j < 32; j++) send_word_b(32'hA5A5_0000 + 32'(j));
  endtask

  function automatic rec_t exp_b(input int k, input logic [31:0] pc);
    rec_t r;
    if (k == 0) begin
      r.sec = 2'd0; r.idx = 5'd0; r.word = pc; r.done = 1'b0;
    end else if (k <= 32) begin
      r.sec = 2'd1; r.idx = 5'(k - 1); r.word = 32'(k - 1); r.done = 1'b0;
    end else begin
      r.sec = 2'd2; r.idx = 5'(k - 33); r.word = 32'hA5A5_0000 + 32'(k - 33); r.done = (k == 64);
    end
    return r;
  endfunction

  task automatic check_frame_b(input string tag, input logic [31:0] pc);
    chk({tag, "_strobes"}, 64'(cap_b.size()), 64'd65);
    for (int k = 0; k < 65 && k < cap_b.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(cap_b[k]), 64'(exp_b(k, pc)));
  endtask

  initial begin
    logic [7:0] s_bytes [14];
    rec_t       s_exp [7];

    checks = 0; errors = 0; err_b = 0; err_s = 0;
    rst = 1'b1;
    b_rx_done = 1'b0; b_flush = 1'b0; b_rx_byte = 8'h00;
    s_rx_done = 1'b0; s_flush = 1'b0; s_rx_byte = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_word_valid", 64'(b_word_valid), 64'd0);
    chk("rst_word", 64'(b_word), 64'd0);
    chk("rst_section", 64'(b_section), 64'd0);
    chk("rst_index", 64'(b_index), 64'd0);
    chk("rst_frame_done", 64'(b_frame_done), 64'd0);
    chk("rst_frame_error", 64'(b_frame_error), 64'd0);
    chk("rst_busy", 64'(b_busy), 64'd0);
    chk("rst_frame_count", 64'(b_frame_count), 64'd0);
    chk("rst_s_busy", 64'(s_busy), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 16-bit configuration, back-to-back bytes
    s_bytes = '{8'h34, 8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
                8'h04, 8'h00, 8'hCD, 8'hAB, 8'hEF, 8'hBE};
    s_exp[0] = '{2'd0, 5'd0, 32'h0000_1234, 1'b0};
    s_exp[1] = '{2'd1, 5'd0, 32'h0000_0001, 1'b0};
    s_exp[2] = '{2'd1, 5'd1, 32'h0000_0002, 1'b0};
    s_exp[3] = '{2'd1, 5'd2, 32'h0000_0003, 1'b0};
    s_exp[4] = '{2'd1, 5'd3, 32'h0000_0004, 1'b0};
    s_exp[5] = '{2'd2, 5'd0, 32'h0000_ABCD, 1'b0};
    s_exp[6] = '{2'd2, 5'd1, 32'h0000_BEEF, 1'b1};
    for (int i = 0; i < 14; i++) begin
      s_rx_byte = s_bytes[i];
      s_rx_done = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        chk("s_latency_valid", 64'(s_word_valid), 64'd1);
        chk("s_latency_word", 64'(s_word), 64'h1234);
      end
    end
    s_rx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("s_strobes", 64'(cap_s.size()), 64'd7);
    for (int k = 0; k < 7 && k < cap_s.size(); k++)
      chk($sformatf("s_w%0d", k), 64'(cap_s[k]), 64'(s_exp[k]));
    chk("s_frame_count", 64'(s_frame_count), 64'd1);
    chk("s_busy_after", 64'(s_busy), 64'd0);
    chk("s_no_error", 64'(err_s), 64'd0);

    // inter-byte timeout after 10 bytes
    send_b(8'h04);
    chk("to_busy_rise", 64'(b_busy), 64'd1);
    send_b(8'h00); send_b(8'h00); send_b(8'h00);
    send_word_b(32'h0000_0000);
    send_b(8'h01); send_b(8'h00);
    repeat (100) @(negedge clk);
    chk("to_error_early", 64'(b_frame_error), 64'd0);
    chk("to_busy_held", 64'(b_busy), 64'd1);
    @(negedge clk);
    chk("to_error_pulse", 64'(b_frame_error), 64'd1);
    chk("to_busy_fall", 64'(b_busy), 64'd0);
    @(negedge clk);
    chk("to_error_one_cycle", 64'(b_frame_error), 64'd0);
    repeat (5) @(negedge clk);
    chk("to_error_count", 64'(err_b), 64'd1);
    chk("to_strobes", 64'(cap_b.size()), 64'd2);
    chk("to_frame_count", 64'(b_frame_count), 64'd0);

    cap_b.delete();
    send_frame_b(32'h0000_0004);
    repeat (3) @(negedge clk);
    check_frame_b("f1", 32'h0000_0004);
    chk("f1_frame_count", 64'(b_frame_count), 64'd1);
    chk("f1_busy", 64'(b_busy), 64'd0);
    chk("f1_error_count", 64'(err_b), 64'd1);

    // flush with a byte in the same cycle, inside REG word 3
    cap_b.delete();
    send_word_b(32'h0000_0004);
    send_word_b(32'd0); send_word_b(32'd1); send_word_b(32'd2);
    send_b(8'h03); send_b(8'h00);
    b_rx_byte = 8'h00;
    b_rx_done = 1'b1;
    b_flush = 1'b1;
    @(negedge clk);
    b_rx_done = 1'b0;
    b_flush = 1'b0;
    chk("fl_busy", 64'(b_busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("fl_strobes", 64'(cap_b.size()), 64'd4);
    chk("fl_no_error", 64'(err_b), 64'd1);
    cap_b.delete();
    send_frame_b(32'h0000_0100);
    repeat (3) @(negedge clk);
    check_frame_b("f2", 32'h0000_0100);
    chk("f2_frame_count", 64'(b_frame_count), 64'd2);

    // asynchronous reset in the middle of MEM word 10
    cap_b.delete();
    send_word_b(32'h0000_0004);
    for (int i = 0; i < 32; i++) send_word_b(32'(i));
    for (int j = 0; j < 10; j++) send_word_b(32'hA5A5_0000 + 32'(j));
    send_b(8'h0A); send_b(8'h00);
    chk("mr_busy_before", 64'(b_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_word_valid", 64'(b_word_valid), 64'd0);
    chk("mr_word", 64'(b_word), 64'd0);
    chk("mr_section", 64'(b_section), 64'd0);
    chk("mr_index", 64'(b_index), 64'd0);
    chk("mr_busy", 64'(b_busy), 64'd0);
    chk("mr_frame_count", 64'(b_frame_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_b.delete();
    send_frame_b(32'h0000_0004);
    repeat (3) @(negedge clk);
    check_frame_b("f3", 32'h0000_0004);
    chk("f3_frame_count", 64'(b_frame_count), 64'd1);

    // frame counter wrap
    force b_dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release b_dut.frame_cnt;
    @(negedge clk);
    chk("wrap_preset", 64'(b_frame_count), 64'hFFFF);
    cap_b.delete();
    send_frame_b(32'h0000_0004);
    repeat (3) @(negedge clk);
    chk("wrap_strobes", 64'(cap_b.size()), 64'd65);
    chk("wrap_frame_count", 64'(b_frame_count), 64'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_frame_collector.md
# debug_frame_collector

Synthesisable receiver for the debug unit's dump stream. It sits behind a UART receiver and consumes the byte stream the MIPS debug unit emits after each step or run: PC, then N_REGS register words, then N_MEM data-memory words. It assembles little-endian words, tags each word with its section and index, and flags frame completion or framing errors. It generalises the fixed 32-bit, 32-register, 32-word dump format: word width, register count and memory count are parameters, and it adds an inter-byte timeout and a flush.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, UART data width.
- N_REGS, 32, register words per frame; must be ≥1.
- N_MEM, 32, memory words per frame; must be ≥1.
- IDX_WIDTH, 5, index width; 2^IDX_WIDTH ≥ max(N_REGS, N_MEM).
- TIMEOUT_CYCLES, 65535, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_rx_done  in  1  one-cycle strobe; i_rx_byte is valid.
- i_rx_byte  in  BYTE_WIDTH  received byte.
- i_flush  in  1  abort the current frame and return to IDLE.
- o_word_valid  out  1  one-cycle strobe; o_word, o_section and o_index are valid.
- o_word  out  DATA_WIDTH  assembled word.
- o_section  out  2  section tag: 0 = PC, 1 = REG, 2 = MEM.
- o_index  out  IDX_WIDTH  word index within its section; always 0 for PC.
- o_frame_done  out  1  one-cycle pulse when a frame completes.
- o_frame_error  out  1  one-cycle pulse when an inter-byte timeout aborts a frame.
- o_busy  out  1  high while the state is not IDLE.
- o_frame_count  out  16  number of completed frames; wraps.

## Operation
- BPW = DATA_WIDTH/BYTE_WIDTH. Bytes are little-endian: the first byte of a word lands in [BYTE_WIDTH-1:0].
- States and transitions:
  - IDLE: on i_rx_done, go to S_PC and take that byte as byte 0.
  - S_PC: after BPW bytes, go to S_REG.
  - S_REG: after N_REGS words, go to S_MEM.
  - S_MEM: after N_MEM words, go to IDLE.
- Counters:
  - byte_cnt runs 0..BPW-1.
  - word_idx runs 0..N-1 and clears on each section change.
- Each completed word emits exactly one o_word_valid with its section and index.
  - A full frame produces 1+N_REGS+N_MEM strobes.
- The final MEM word also pulses o_frame_done, and o_frame_count increments (0xFFFF wraps to 0x0000).
- Timeout:
  - An idle counter resets on every i_rx_done and counts up in any non-IDLE state.
  - When it reaches TIMEOUT_CYCLES, pulse o_frame_error, discard the partial word, go to IDLE, and leave o_frame_count unchanged.
- i_flush: the next state is IDLE and all counters clear. There is no error pulse and no word strobe.
- i_flush together with i_rx_done: flush wins and the byte is discarded.
- i_rx_done arriving in the timeout cycle: the timeout wins and the byte is discarded.
- Back-to-back strobes (i_rx_done on consecutive cycles) must be accepted without loss.

## Timing
- Reset values:
  - o_word_valid = 0, o_frame_done = 0, o_frame_error = 0, o_busy = 0.
  - o_word = 0, o_section = 0, o_index = 0, o_frame_count = 0.
  - State IDLE, all counters 0.
- Latency: o_word_valid rises 1 cycle after the i_rx_done carrying the last byte of a word.
- o_frame_done is coincident with the last o_word_valid.
- o_word, o_section and o_index are registered and hold until the next strobe.
- o_busy rises 1 cycle after the first byte and falls 1 cycle after the last byte, a flush, or a timeout.
- o_frame_error rises 1 cycle after the idle counter reaches TIMEOUT_CYCLES.
- Reset mid-frame: everything clears immediately and asynchronously. The next byte starts a new frame.

## Structure
- Package debug_pkg holds:
  - section encodings: SEC_PC, SEC_REG, SEC_MEM;
  - the state enum: IDLE, S_PC, S_REG, S_MEM;
  - the BPW helper function.
- Sub-module debug_word_assembler:
  - a byte shift-in register with byte_cnt and a word-complete flag;
  - cleared by flush or timeout.
- The top level contains the FSM, index counters, timeout counter and frame counter.

## Test plan
- Default parameters, one frame with PC = 0x00000004, reg[i] = i, mem[j] = 0xA5A5_0000+j (260 bytes):
  - 65 word_valids with correct section and index;
  - o_word = 0x00000004 for PC;
  - reg index 31 = 0x1F;
  - o_frame_done is coincident with mem index 31;
  - o_frame_count = 1.
- TIMEOUT_CYCLES = 100; send 10 bytes, then go idle for 100 cycles:
  - o_frame_error pulses once, o_busy falls, and there is no 3rd word strobe;
  - a following full frame completes cleanly with o_frame_count = 1.
- Flush in the middle of REG word 3, with i_rx_done in the same cycle:
  - no strobe for that word and no error;
  - o_busy = 0 next cycle;
  - the next byte starts at PC byte 0.
- DATA_WIDTH = 16, N_REGS = 4, N_MEM = 2, IDX_WIDTH = 2, back-to-back bytes:
  - 14 bytes produce 7 strobes;
  - bytes 0x34, 0x12 give o_word = 0x1234.
- Assert i_reset during MEM word 10:
  - all outputs return to reset values;
  - the next 260 bytes give one clean frame.
- Force o_frame_count to 0xFFFF, then complete one frame: o_frame_count = 0x0000.
